// File: rtl/cpld_frame_if.sv
// Serial frame link to the board CPLD: shifts out LED + multiplexed hex digit frames,
// samples switch bits back on the same frame and debounces them across frames.
module cpld_frame_if #(
    parameter int unsigned DIV_LOG2   = 10,
    parameter int unsigned N_LED      = 8,
    parameter int unsigned N_DIG      = 2,
    parameter int unsigned N_SW       = 8,
    parameter int unsigned DEB_FRAMES = 2
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic [N_LED-1:0]   led_i,
    input  logic [4*N_DIG-1:0] dig_i,
    input  logic [N_DIG-1:0]   dp_i,
    input  logic [N_DIG-1:0]   blank_i,
    output logic [N_SW-1:0]    sw_o,
    output logic               sw_chg_o,
    output logic               sw_valid_o,
    output logic               frame_done_o,
    output logic               cpld_rstn_o,
    output logic               cpld_clk_o,
    output logic               cpld_load_o,
    output logic               cpld_mosi_o,
    input  logic               cpld_miso_i
);

    localparam int unsigned FRAME_W = N_LED + N_DIG + 8;
    localparam int unsigned BW      = $clog2(FRAME_W);
    localparam int unsigned DW      = (N_DIG > 1) ? $clog2(N_DIG) : 1;

    localparam logic [BW-1:0] LastBit = BW'(FRAME_W - 1);
    localparam logic [DW-1:0] LastDig = DW'(N_DIG - 1);
    localparam logic [3:0]    DebMax  = 4'(DEB_FRAMES - 1);

    typedef enum logic {StWait, StShift} state_e;

    state_e               state_q, state_d;
    logic [1:0]           rst_sync_q;
    logic                 cpld_rstn;
    logic [DIV_LOG2-1:0]  wcnt_q;
    logic [DIV_LOG2-1:0]  pcnt_q;
    logic [BW-1:0]        bcnt_q;
    logic [DW-1:0]        dcnt_q, dig_nxt;
    logic [FRAME_W-1:0]   tx_shr_q, frame_d;
    logic [N_SW-1:0]      raw_q, raw_full, prev_q, sw_q;
    logic [3:0]           deb_cnt_q, deb_cnt_d;
    logic                 valid_q, chg_q, done_q;
    logic                 in_shift, wait_done, tick, last, start, accept;
    logic [N_DIG-1:0]     onehot;
    logic [3:0]           nib;
    logic                 sel_dp, sel_blank;
    logic [7:0]           seg;

    // Active-high segment pattern {g,f,e,d,c,b,a} for a hex nibble.
    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h3F;
            4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;
            4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;
            4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;
            4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;
            4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

    // Two-flop synchronised release of the CPLD reset.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) rst_sync_q <= 2'b00;
        else         rst_sync_q <= {rst_sync_q[0], 1'b1};
    end

    assign cpld_rstn = rst_sync_q[1];

    assign in_shift  = (state_q == StShift);
    assign wait_done = (state_q == StWait) && cpld_rstn && (&wcnt_q);
    assign tick      = in_shift && (&pcnt_q);
    assign last      = tick && (bcnt_q == LastBit);
    // A frame starts on leaving the wait state and on every frame wrap.
    assign start     = wait_done || last;
    assign dig_nxt   = last ? ((dcnt_q == LastDig) ? '0 : dcnt_q + 1'b1) : dcnt_q;

    // FSM state register.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) state_q <= StWait;
        else         state_q <= state_d;
    end

    // FSM next state: one idle bit period after CPLD reset release, then frames forever.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StWait:  if (wait_done) state_d = StShift;
            StShift: state_d = StShift;
            default: state_d = StWait;
        endcase
    end

    // FSM outputs: serial pins are held low until shifting starts.
    always_comb begin
        cpld_clk_o  = 1'b0;
        cpld_load_o = 1'b0;
        cpld_mosi_o = 1'b0;
        if (in_shift) begin
            cpld_clk_o  = pcnt_q[DIV_LOG2-1];
            cpld_load_o = (bcnt_q == LastBit);
            cpld_mosi_o = tx_shr_q[0];
        end
    end

    // Frame word for the digit that the starting frame will show.
    always_comb begin
        onehot    = '0;
        nib       = '0;
        sel_dp    = 1'b0;
        sel_blank = 1'b0;
        for (int i = 0; i < N_DIG; i++) begin
            if (dig_nxt == DW'(i)) begin
                onehot[i] = 1'b1;
                nib       = dig_i[4*i +: 4];
                sel_dp    = dp_i[i];
                sel_blank = blank_i[i];
            end
        end
        seg     = sel_blank ? 8'h00 : {sel_dp, hex7(nib)};
        frame_d = {seg, onehot, led_i};
    end

    // Wait timer, bit prescaler, bit counter, digit index and transmit shifter.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wcnt_q   <= '0;
            pcnt_q   <= '0;
            bcnt_q   <= '0;
            dcnt_q   <= '0;
            tx_shr_q <= '0;
        end else begin
            wcnt_q <= ((state_q == StWait) && cpld_rstn) ? wcnt_q + 1'b1 : '0;
            pcnt_q <= in_shift ? pcnt_q + 1'b1 : '0;
            if (last)      bcnt_q <= '0;
            else if (tick) bcnt_q <= bcnt_q + 1'b1;
            dcnt_q <= dig_nxt;
            if (start)     tx_shr_q <= frame_d;
            else if (tick) tx_shr_q <= tx_shr_q >> 1;
        end
    end

    // Raw switch word including the bit sampled on the current tick.
    always_comb begin
        raw_full = raw_q;
        for (int k = 0; k < N_SW; k++) begin
            if (tick && (bcnt_q == BW'(k))) raw_full[k] = cpld_miso_i;
        end
    end

    // Debounce decision evaluated on the last tick of each frame.
    always_comb begin
        if (raw_full == prev_q) deb_cnt_d = (deb_cnt_q == DebMax) ? DebMax : deb_cnt_q + 4'd1;
        else                    deb_cnt_d = 4'd0;
        accept = last && (deb_cnt_d == DebMax) && ((raw_full != sw_q) || !valid_q);
    end

    // Switch capture, debounce history and status pulses.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            raw_q     <= '0;
            prev_q    <= '0;
            deb_cnt_q <= '0;
            sw_q      <= '0;
            valid_q   <= 1'b0;
            chg_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            raw_q  <= raw_full;
            done_q <= last;
            chg_q  <= accept && (raw_full != sw_q);
            if (last) begin
                prev_q    <= raw_full;
                deb_cnt_q <= deb_cnt_d;
            end
            if (accept) begin
                sw_q    <= raw_full;
                valid_q <= 1'b1;
            end
        end
    end

    assign sw_o         = sw_q;
    assign sw_chg_o     = chg_q;
    assign sw_valid_o   = valid_q;
    assign frame_done_o = done_q;
    assign cpld_rstn_o  = cpld_rstn;

endmodule

// File: tb/tb_cpld_frame_if.sv
// Bench for cpld_frame_if: two instances (2 digits / debounce 2, 3 digits / debounce 1)
// against a frame-timeline model, plus literal expectations for the key scenarios.
module tb_cpld_frame_if;

    localparam int P = 4;  // clk cycles per bit slot

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [7:0]  led;
    logic [11:0] dig;
    logic [2:0]  dp, blank;
    logic        miso_a, miso_b;

    logic [7:0]  sw_a;
    logic        chg_a, valid_a, done_a, crst_a, cclk_a, load_a, mosi_a;
    logic [18:0] sw_b;
    logic        chg_b, valid_b, done_b, crst_b, cclk_b, load_b, mosi_b;

    always #5 clk = ~clk;

    cpld_frame_if #(.DIV_LOG2(2), .N_LED(8), .N_DIG(2), .N_SW(8), .DEB_FRAMES(2)) u_a (
        .clk_i(clk), .rstn_i(rstn), .led_i(led), .dig_i(dig[7:0]), .dp_i(dp[1:0]),
        .blank_i(blank[1:0]), .sw_o(sw_a), .sw_chg_o(chg_a), .sw_valid_o(valid_a),
        .frame_done_o(done_a), .cpld_rstn_o(crst_a), .cpld_clk_o(cclk_a),
        .cpld_load_o(load_a), .cpld_mosi_o(mosi_a), .cpld_miso_i(miso_a)
    );

    cpld_frame_if #(.DIV_LOG2(2), .N_LED(8), .N_DIG(3), .N_SW(19), .DEB_FRAMES(1)) u_b (
        .clk_i(clk), .rstn_i(rstn), .led_i(led), .dig_i(dig), .dp_i(dp),
        .blank_i(blank), .sw_o(sw_b), .sw_chg_o(chg_b), .sw_valid_o(valid_b),
        .frame_done_o(done_b), .cpld_rstn_o(crst_b), .cpld_clk_o(cclk_b),
        .cpld_load_o(load_b), .cpld_mosi_o(mosi_b), .cpld_miso_i(miso_b)
    );

    int pass_cnt = 0;
    int chk_cnt  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        chk_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    // ---------------- behavioural model (per instance u) ----------------
    int nd[2]  = '{2, 3};
    int nsw[2] = '{8, 19};
    int deb[2] = '{2, 1};

    int rs[2], wt[2], t[2], dg[2], fr[2], cnt[2];
    bit run[2], vld[2], chg[2], done[2];
    logic [31:0] snap[2], word[2], prevr[2], swm[2];

    logic [7:0] hexseg[16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                               8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
    logic [31:0] dlist[5] = '{32'h5A, 32'h5A, 32'hFF, 32'h5A, 32'h5A};

    function automatic logic [31:0] build(input int u, input int d);
        logic [3:0] n;
        logic [7:0] s;
        n = dig[4*d +: 4];
        s = blank[d] ? 8'h00 : {dp[d], hexseg[n][6:0]};
        return 32'(led) | (32'd1 << (8 + d)) | (32'(s) << (8 + nd[u]));
    endfunction

    task automatic start_frame(input int u);
        snap[u] = build(u, dg[u]);
        if (fr[u] < 5) word[u] = dlist[fr[u]];
        else if ($urandom_range(1, 0) == 0) word[u] = $urandom;
    endtask

    task automatic end_frame(input int u);
        logic [31:0] raw;
        raw = word[u] & ((32'd1 << nsw[u]) - 1);
        if (raw == prevr[u]) cnt[u] = (cnt[u] + 1 > deb[u] - 1) ? deb[u] - 1 : cnt[u] + 1;
        else cnt[u] = 0;
        prevr[u] = raw;
        if (cnt[u] == deb[u] - 1 && (raw != swm[u] || !vld[u])) begin
            chg[u] = (raw != swm[u]);
            swm[u] = raw;
            vld[u] = 1'b1;
        end
        done[u] = 1'b1;
    endtask

    task automatic model_step(input int u);
        if (!rstn) begin
            rs[u] = 0; wt[u] = 0; run[u] = 0; t[u] = 0; dg[u] = 0; fr[u] = 0; cnt[u] = 0;
            vld[u] = 0; chg[u] = 0; done[u] = 0;
            snap[u] = 0; word[u] = 0; prevr[u] = 0; swm[u] = 0;
        end else begin
            done[u] = 0;
            chg[u]  = 0;
            if (rs[u] < 2) rs[u]++;
            else if (!run[u]) begin
                wt[u]++;
                if (wt[u] == P) begin
                    run[u] = 1; t[u] = 0;
                    start_frame(u);
                end
            end else begin
                t[u]++;
                if (t[u] == P * (nd[u] + 16)) begin
                    end_frame(u);
                    t[u] = 0;
                    dg[u] = (dg[u] + 1) % nd[u];
                    fr[u]++;
                    start_frame(u);
                end
            end
        end
    endtask

    function automatic logic [38:0] expv(input int u);
        int s;
        s = t[u] / P;
        return {swm[u], chg[u], vld[u], done[u], (rs[u] == 2), run[u] && (t[u] % P >= P / 2),
                run[u] && (s == nd[u] + 15), run[u] ? snap[u][s] : 1'b0};
    endfunction

    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) model_step(u);
    end

    // CPLD side: return bit k of the frame's switch word during slot k.
    function automatic logic miso_bit(input int u);
        if (run[u] && (t[u] / P) < nsw[u]) return word[u][t[u] / P];
        return 1'($urandom);
    endfunction

    always @(negedge clk) begin
        miso_a = miso_bit(0);
        miso_b = miso_bit(1);
    end

    // ---------------- compare and frame capture ----------------
    logic [31:0] cap[2];
    logic [31:0] capq_a[$];
    logic [31:0] capq_b[$];
    int chg_seen_a = 0;

    always @(posedge clk) begin
        #1;
        check("outputs_a", {32'(sw_a), chg_a, valid_a, done_a, crst_a, cclk_a, load_a, mosi_a},
              64'(expv(0)));
        check("outputs_b", {32'(sw_b), chg_b, valid_b, done_b, crst_b, cclk_b, load_b, mosi_b},
              64'(expv(1)));
        if (chg_a) chg_seen_a++;
        if (!rstn) begin
            capq_a.delete();
            capq_b.delete();
            cap[0] = 0;
            cap[1] = 0;
        end else begin
            if (done[0]) capq_a.push_back(cap[0]);
            if (done[1]) capq_b.push_back(cap[1]);
            for (int u = 0; u < 2; u++) begin
                if (run[u] && t[u] % P == 0) begin
                    if (t[u] == 0) cap[u] = 0;
                    cap[u][t[u] / P] = (u == 0) ? mosi_a : mosi_b;
                end
            end
        end
    end

    function automatic int qsize(input int u);
        return (u == 0) ? capq_a.size() : capq_b.size();
    endfunction

    function automatic logic [31:0] qget(input int u, input int i);
        if (i >= qsize(u)) return 32'hDEAD_BEEF;
        return (u == 0) ? capq_a[i] : capq_b[i];
    endfunction

    task automatic wait_cap(input int u, input int n);
        int k;
        k = 0;
        while (qsize(u) < n && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (qsize(u) < n) check("frame_timeout", 64'(qsize(u)), 64'(n));
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        int k;
        led = 8'hA5; dig = 12'h231; dp = 3'b000; blank = 3'b000;
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1 check("cpld_rstn_edge1", 64'(crst_a), 64'd0);
        @(posedge clk); #1 check("cpld_rstn_edge2", 64'(crst_a), 64'd1);

        wait_cap(0, 1);
        check("valid_after_frame1", 64'(valid_a), 64'd0);
        dp = 3'b010; blank = 3'b010;  // lands on the next frame (digit 1)

        wait_cap(0, 2);
        check("sw_after_frame2", 64'(sw_a), 64'h5A);
        check("valid_after_frame2", 64'(valid_a), 64'd1);
        check("chg_count_frame2", 64'(chg_seen_a), 64'd1);
        check("frame0_bits", 64'(qget(0, 0)), 64'h19A5);
        check("frame1_bits", 64'(qget(0, 1)), 64'h13EA5);
        check("b_frame0_bits", 64'(qget(1, 0)), 64'h31A5);

        wait_cap(0, 4);
        check("frame2_bits_dig0", 64'(qget(0, 2)), 64'h19A5);
        check("frame3_blanked", 64'(qget(0, 3)), 64'h2A5);

        wait_cap(0, 5);
        check("sw_after_glitch", 64'(sw_a), 64'h5A);
        check("chg_count_frame5", 64'(chg_seen_a), 64'd1);

        dp = 3'b000; blank = 3'b000;
        for (int i = 0; i < 1800; i++) begin
            @(negedge clk);
            if ($urandom_range(19, 0) == 0) begin
                led = 8'($urandom); dig = 12'($urandom);
                dp = 3'($urandom); blank = 3'($urandom);
            end
        end

        // Abort mid-frame during bit slot 7 of instance A.
        k = 0;
        while (!(run[0] && t[0] / P == 7) && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("reached_slot7", 64'(run[0] && t[0] / P == 7), 64'd1);
        rstn = 1'b0;
        #1;
        check("reset_zero_a", {32'(sw_a), chg_a, valid_a, done_a, crst_a, cclk_a, load_a, mosi_a},
              64'd0);
        check("reset_zero_b", {32'(sw_b), chg_b, valid_b, done_b, crst_b, cclk_b, load_b, mosi_b},
              64'd0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;

        wait_cap(1, 4);
        check("a_digit_after_reset", 64'((qget(0, 0) >> 8) & 32'h3), 64'd1);
        check("b_digit_order0", 64'((qget(1, 0) >> 8) & 32'h7), 64'd1);
        check("b_digit_order1", 64'((qget(1, 1) >> 8) & 32'h7), 64'd2);
        check("b_digit_order2", 64'((qget(1, 2) >> 8) & 32'h7), 64'd4);
        check("b_digit_order3", 64'((qget(1, 3) >> 8) & 32'h7), 64'd1);

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
